// File: rtl/ram_sync_clr.sv
// Parametrised single-port synchronous RAM with a hardware clear sequencer, ready flag and out-of-range error.
// Optional per-byte write enables are built when RAM_BYTE_WE_EN is defined.
module ram_sync_clr #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          cen,
  input  logic          wen,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
`ifdef RAM_BYTE_WE_EN
  input  logic [DW/8-1:0] be,
`endif
  output logic [DW-1:0] dout,
  output logic          ready,
  output logic          err
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);

  state_t        state, state_d;
  logic [AW-1:0] clr_ptr, clr_ptr_d;
  logic [DW-1:0] dout_d;
  logic          err_d;
  logic          in_range;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem [DEPTH];

`ifdef RAM_BYTE_WE_EN
  localparam int NB = DW / 8;
  logic [NB-1:0] mem_wbe;
`endif

  // Unsigned compare on AW+1 bits so DEPTH == 2**AW still fits.
  assign in_range = ({1'b0, addr} < (AW+1)'(DEPTH));
  assign ready    = (state == S_IDLE);

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    clr_ptr_d = clr_ptr;
    dout_d    = '0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = din;
`ifdef RAM_BYTE_WE_EN
    mem_wbe   = '1;
`endif
    case (state)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr;
        mem_wdata = '0;
        if (clr_ptr == LAST_WORD) begin
          state_d   = S_IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr + AW'(1);
        end
      end
      S_IDLE: begin
        if (clr) begin
          state_d   = S_CLEAR;
          clr_ptr_d = '0;
        end else if (cen) begin
          if (!in_range) begin
            err_d = 1'b1;
          end else if (wen) begin
            mem_we = 1'b1;
`ifdef RAM_BYTE_WE_EN
            mem_wbe = be;
`endif
          end else begin
            dout_d = mem[addr];
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
    // Reset aborts whatever write this cycle would have made.
    if (rst) mem_we = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_ptr <= '0;
      dout    <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      clr_ptr <= clr_ptr_d;
      dout    <= dout_d;
      err     <= err_d;
    end
  end

  // NOTE: the array itself has no reset; the clear sequencer defines its contents, keeping it mappable to RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
`ifdef RAM_BYTE_WE_EN
      for (int b = 0; b < NB; b++) begin
        if (mem_wbe[b]) mem[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
`else
      mem[mem_waddr] <= mem_wdata;
`endif
    end
  end

endmodule

// File: tb/tb_ram_sync_clr.sv
// Directed bench for ram_sync_clr: a 32-word instance and a 20-word instance share one stimulus stream.
// Byte-enable scenario runs only when RAM_BYTE_WE_EN is defined.
module tb_ram_sync_clr;

  logic        clk = 1'b0;
  logic        rst, clr, cen, wen;
  logic [4:0]  addr;
  logic [31:0] din;
  logic [31:0] dout, dout20;
  logic        ready, ready20, err, err20;
`ifdef RAM_BYTE_WE_EN
  logic [3:0]  be;
`endif

  int errors = 0;
  int checks = 0;
  logic [31:0] m20 [20];

  always #5 clk = ~clk;

  ram_sync_clr #(.DW(32), .DEPTH(32), .AW(5)) u_dut (
    .clk(clk), .rst(rst), .clr(clr), .cen(cen), .wen(wen), .addr(addr), .din(din),
`ifdef RAM_BYTE_WE_EN
    .be(be),
`endif
    .dout(dout), .ready(ready), .err(err)
  );

  ram_sync_clr #(.DW(32), .DEPTH(20), .AW(5)) u_dut20 (
    .clk(clk), .rst(rst), .clr(clr), .cen(cen), .wen(wen), .addr(addr), .din(din),
`ifdef RAM_BYTE_WE_EN
    .be(be),
`endif
    .dout(dout20), .ready(ready20), .err(err20)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic c, input logic w, input logic [4:0] a, input logic [31:0] d);
    clr  = 1'b0;
    cen  = c;
    wen  = w;
    addr = a;
    din  = d;
    tick();
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b1, a, d);
    if (a < 5'd20) m20[a] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; cen = 1'b1; wen = 1'b1; addr = 5'd3; din = '1;
    tick();
    tick();
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout got=%h exp=0", dout); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
    rst = 1'b0; cen = 1'b0; wen = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      checks++; if (ready !== (i == 32)) begin errors++; $display("FAIL init_ready cyc=%0d got=%b exp=%b", i, ready, i == 32); end
      checks++; if (ready20 !== (i >= 20)) begin errors++; $display("FAIL init_ready20 cyc=%0d got=%b exp=%b", i, ready20, i >= 20); end
      checks++; if (dout !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL init_outs cyc=%0d dout=%h err=%b exp=0/0", i, dout, err); end
    end
    for (int a = 0; a < 32; a++) begin
      cycle(1'b1, 1'b0, 5'(a), 32'h0);
      checks++; if (dout !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL init_read a=%0d dout=%h err=%b exp=0/0", a, dout, err); end
      checks++; if (dout20 !== 32'h0 || err20 !== (a >= 20)) begin errors++; $display("FAIL init_read20 a=%0d dout=%h err=%b exp=0/%b", a, dout20, err20, a >= 20); end
    end
    for (int a = 0; a < 20; a++) m20[a] = 32'h0;
  endtask

  task automatic test_write_read();
    wr(5'd5, 32'hDEADBEEF);
    checks++; if (dout !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL wr5_outs dout=%h err=%b exp=0/0", dout, err); end
    cycle(1'b1, 1'b0, 5'd5, 32'h0);
    checks++; if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL rd5 got=%h exp=deadbeef", dout); end
    wr(5'd6, 32'hCAFEF00D);
    cycle(1'b1, 1'b0, 5'd6, 32'h0);
    checks++; if (dout !== 32'hCAFEF00D) begin errors++; $display("FAIL rd6 got=%h exp=cafef00d", dout); end
    cycle(1'b1, 1'b0, 5'd5, 32'h0);
    checks++; if (dout !== 32'hDEADBEEF) begin errors++; $display("FAIL rd5_b2b got=%h exp=deadbeef", dout); end
    cycle(1'b0, 1'b0, 5'd5, 32'h0);
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL idle_dout got=%h exp=0", dout); end
  endtask

  task automatic test_cen_low();
    wr(5'd7, 32'h13579BDF);
    cycle(1'b0, 1'b1, 5'd7, 32'hFFFFFFFF);
    checks++; if (dout !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL cen0_outs dout=%h err=%b exp=0/0", dout, err); end
    cycle(1'b1, 1'b0, 5'd7, 32'h0);
    checks++; if (dout !== 32'h13579BDF) begin errors++; $display("FAIL cen0_keep got=%h exp=13579bdf", dout); end
  endtask

  task automatic test_out_of_range();
    cycle(1'b1, 1'b1, 5'd25, 32'h5A5A5A5A);
    checks++; if (err20 !== 1'b1 || dout20 !== 32'h0) begin errors++; $display("FAIL oor_wr25 err=%b dout=%h exp=1/0", err20, dout20); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_depth_err25 got=%b exp=0", err); end
    cycle(1'b1, 1'b0, 5'd3, 32'h0);
    checks++; if (err20 !== 1'b0 || dout20 !== m20[3]) begin errors++; $display("FAIL oor_clear err=%b dout=%h exp=0/%h", err20, dout20, m20[3]); end
    cycle(1'b1, 1'b0, 5'd20, 32'h0);
    checks++; if (err20 !== 1'b1) begin errors++; $display("FAIL oor_a20 got=%b exp=1", err20); end
    cycle(1'b1, 1'b0, 5'd19, 32'h0);
    checks++; if (err20 !== 1'b0 || dout20 !== m20[19]) begin errors++; $display("FAIL oor_a19 err=%b dout=%h exp=0/%h", err20, dout20, m20[19]); end
    cycle(1'b1, 1'b0, 5'd31, 32'h0);
    checks++; if (err20 !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL oor_a31 err20=%b err=%b exp=1/0", err20, err); end
    cycle(1'b1, 1'b0, 5'd25, 32'h0);
    checks++; if (dout !== 32'h5A5A5A5A || err20 !== 1'b1) begin errors++; $display("FAIL rd25 dout=%h err20=%b exp=5a5a5a5a/1", dout, err20); end
    cycle(1'b0, 1'b0, 5'd31, 32'h0);
    checks++; if (err20 !== 1'b0) begin errors++; $display("FAIL oor_not_sticky got=%b exp=0", err20); end
    for (int a = 0; a < 20; a++) begin
      cycle(1'b1, 1'b0, 5'(a), 32'h0);
      checks++; if (dout20 !== m20[a]) begin errors++; $display("FAIL oor_nochange a=%0d got=%h exp=%h", a, dout20, m20[a]); end
    end
  endtask

  task automatic test_clear();
    for (int a = 0; a < 32; a++) wr(5'(a), 32'h1000_0001 + 32'(a) * 32'h0101);
    clr = 1'b1; cen = 1'b1; wen = 1'b0; addr = 5'd5;
    tick();
    checks++; if (ready !== 1'b0 || dout !== 32'h0) begin errors++; $display("FAIL clr_edge ready=%b dout=%h exp=0/0", ready, dout); end
    wen = 1'b1; addr = 5'd0; din = 32'hFFFFFFFF;
    for (int i = 1; i <= 32; i++) begin
      clr = (i == 20);
      tick();
      checks++; if (ready !== (i == 32)) begin errors++; $display("FAIL clr_ready cyc=%0d got=%b exp=%b", i, ready, i == 32); end
      checks++; if (dout !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL clr_outs cyc=%0d dout=%h err=%b exp=0/0", i, dout, err); end
    end
    for (int a = 0; a < 20; a++) m20[a] = 32'h0;
    m20[0] = 32'hFFFFFFFF;
    for (int a = 0; a < 32; a++) begin
      cycle(1'b1, 1'b0, 5'(a), 32'h0);
      checks++; if (dout !== 32'h0) begin errors++; $display("FAIL clr_read a=%0d got=%h exp=0", a, dout); end
    end
    cycle(1'b1, 1'b0, 5'd0, 32'h0);
    checks++; if (dout20 !== m20[0]) begin errors++; $display("FAIL clr20_postwrite got=%h exp=%h", dout20, m20[0]); end
  endtask

  task automatic test_reset_mid_clear();
    for (int a = 0; a < 32; a++) wr(5'(a), 32'h8000_0000 | 32'(a + 1));
    clr = 1'b1; cen = 1'b0;
    tick();
    clr = 1'b0;
    for (int i = 1; i <= 10; i++) tick();
    rst = 1'b1;
    tick();
    checks++; if (ready !== 1'b0 || dout !== 32'h0) begin errors++; $display("FAIL midrst ready=%b dout=%h exp=0/0", ready, dout); end
    rst = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      checks++; if (ready !== (i == 32)) begin errors++; $display("FAIL midrst_ready cyc=%0d got=%b exp=%b", i, ready, i == 32); end
    end
    for (int a = 0; a < 20; a++) m20[a] = 32'h0;
    for (int a = 0; a < 32; a++) begin
      cycle(1'b1, 1'b0, 5'(a), 32'h0);
      checks++; if (dout !== 32'h0) begin errors++; $display("FAIL midrst_read a=%0d got=%h exp=0", a, dout); end
    end
  endtask

`ifdef RAM_BYTE_WE_EN
  task automatic test_byte_enable();
    be = 4'hF;
    wr(5'd2, 32'h11223344);
    be = 4'b0101;
    wr(5'd2, 32'hAABBCCDD);
    be = 4'b0000;
    cycle(1'b1, 1'b0, 5'd2, 32'h0);
    checks++; if (dout !== 32'h11BB33DD) begin errors++; $display("FAIL byte_we got=%h exp=11bb33dd", dout); end
    be = 4'hF;
  endtask
`endif

  initial begin
    rst = 1'b1; clr = 1'b0; cen = 1'b0; wen = 1'b0; addr = '0; din = '0;
`ifdef RAM_BYTE_WE_EN
    be = 4'hF;
`endif
    test_reset();
    test_write_read();
    test_cen_low();
    test_out_of_range();
    test_clear();
    test_reset_mid_clear();
`ifdef RAM_BYTE_WE_EN
    test_byte_enable();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
